// File: rtl/lcd_byte_sequencer_pkg.sv
// Shared types and constants for the LCD byte sequencer: FSM states, the
// 4-bit init sequence, init command bytes and microsecond-to-cycle conversion.
package lcd_byte_sequencer_pkg;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_NIB,
        S_INIT_GAP,
        S_IDLE,
        S_HI,
        S_HI_WAIT,
        S_LO,
        S_LO_WAIT
    } lcd_seq_state_t;

    localparam logic [3:0] INIT_NIBS  [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    localparam logic [7:0] INIT_BYTES [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;

    // ceil(clk_hz * us / 1e6), computed in 64 bits so MHz clocks with
    // multi-millisecond waits do not overflow; never returns 0.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        longint unsigned prod;
        int unsigned     cyc;
        prod = 64'(clk_hz) * 64'(us);
        cyc  = 32'((prod + 64'd999_999) / 64'd1_000_000);
        return (cyc == 0) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/lcd_byte_sequencer_if.sv
// Byte-side and nibble-side handshake bundle of the LCD byte sequencer.
interface lcd_byte_sequencer_if;
    logic [7:0] i_byte;
    logic       i_byte_rs;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic [3:0] o_nib_data;
    logic       o_nib_rs;
    logic       o_nib_valid;
    logic       i_nib_ready;
    logic       o_init_done;

    modport slave (
        input  i_byte, i_byte_rs, i_byte_valid, i_nib_ready,
        output o_byte_ready, o_nib_data, o_nib_rs, o_nib_valid, o_init_done
    );

    modport master (
        output i_byte, i_byte_rs, i_byte_valid, i_nib_ready,
        input  o_byte_ready, o_nib_data, o_nib_rs, o_nib_valid, o_init_done
    );
endinterface

// File: rtl/lcd_byte_sequencer_timer.sv
// Cycle delay timer: counts while i_start is held, pulses o_done on the
// i_cycles-th counted cycle and is back at zero whenever i_start is low.
module lcd_delay_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_cycles,
    output logic             o_done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign o_done = i_start && (cnt_q == i_cycles - WIDTH'(1));

    always_comb begin
        cnt_d = '0;
        if (i_start && !o_done) cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lcd_byte_sequencer.sv
// Runs the HD44780 4-bit power-on init, then splits upstream bytes into
// high/low nibbles over a valid/ready handshake to the nibble interface.
module lcd_byte_sequencer
    import lcd_byte_sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 27_000_000,
    parameter int unsigned POWERUP_US    = 40_000,
    parameter int unsigned INIT_WAIT1_US = 4_100,
    parameter int unsigned INIT_WAIT2_US = 100
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    lcd_byte_sequencer_if.slave  bus
);

    localparam int unsigned PWR_CYC   = us_to_cycles(CLK_HZ, POWERUP_US);
    localparam int unsigned WAIT1_CYC = us_to_cycles(CLK_HZ, INIT_WAIT1_US);
    localparam int unsigned WAIT2_CYC = us_to_cycles(CLK_HZ, INIT_WAIT2_US);
    localparam int unsigned MAX_A     = (PWR_CYC > WAIT1_CYC) ? PWR_CYC : WAIT1_CYC;
    localparam int unsigned MAX_CYC   = (MAX_A > WAIT2_CYC) ? MAX_A : WAIT2_CYC;
    localparam int unsigned CW        = $clog2(MAX_CYC + 1);

    lcd_seq_state_t state_q, state_d;
    logic [1:0]     step_q, step_d;
    logic [1:0]     ibyte_q, ibyte_d;
    logic [7:0]     byte_q, byte_d;
    logic           brs_q, brs_d;
    logic [3:0]     nib_data_q, nib_data_d;
    logic           nib_rs_q, nib_rs_d;
    logic           init_done_q, init_done_d;
    logic           gap_run_q, gap_run_d;

    logic           timer_run;
    logic [CW-1:0]  timer_cycles;
    logic           timer_done;
    logic           nib_valid;
    logic [7:0]     next_init_byte;

    assign nib_valid      = (state_q == S_INIT_NIB) || (state_q == S_HI) || (state_q == S_LO);
    assign next_init_byte = INIT_BYTES[ibyte_q + 2'd1];

    // The init gap only starts counting once the downstream reports idle,
    // and keeps counting from then on even if ready toggles.
    assign timer_run    = (state_q == S_PWR_WAIT) ||
                          ((state_q == S_INIT_GAP) && (gap_run_q || bus.i_nib_ready));
    assign timer_cycles = (state_q == S_PWR_WAIT) ? CW'(PWR_CYC)   :
                          (step_q == 2'd0)        ? CW'(WAIT1_CYC) : CW'(WAIT2_CYC);

    lcd_delay_timer #(.WIDTH(CW)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (timer_run),
        .i_cycles (timer_cycles),
        .o_done   (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        ibyte_d     = ibyte_q;
        byte_d      = byte_q;
        brs_d       = brs_q;
        nib_data_d  = nib_data_q;
        nib_rs_d    = nib_rs_q;
        init_done_d = init_done_q;
        gap_run_d   = 1'b0;

        case (state_q)
            S_PWR_WAIT: begin
                if (timer_done) begin
                    state_d    = S_INIT_NIB;
                    step_d     = 2'd0;
                    nib_data_d = INIT_NIBS[0];
                    nib_rs_d   = 1'b0;
                end
            end
            S_INIT_NIB: begin
                if (bus.i_nib_ready) state_d = S_INIT_GAP;
            end
            S_INIT_GAP: begin
                gap_run_d = timer_run && !timer_done;
                if (timer_done) begin
                    if (step_q == 2'd3) begin
                        state_d    = S_HI;
                        ibyte_d    = 2'd0;
                        byte_d     = INIT_BYTES[0];
                        brs_d      = 1'b0;
                        nib_data_d = INIT_BYTES[0][7:4];
                        nib_rs_d   = 1'b0;
                    end else begin
                        state_d    = S_INIT_NIB;
                        step_d     = step_q + 2'd1;
                        nib_data_d = INIT_NIBS[step_q + 2'd1];
                    end
                end
            end
            S_IDLE: begin
                if (bus.i_byte_valid) begin
                    state_d    = S_HI;
                    byte_d     = bus.i_byte;
                    brs_d      = bus.i_byte_rs;
                    nib_data_d = bus.i_byte[7:4];
                    nib_rs_d   = bus.i_byte_rs;
                end
            end
            S_HI: begin
                if (bus.i_nib_ready) state_d = S_HI_WAIT;
            end
            S_HI_WAIT: begin
                if (bus.i_nib_ready) begin
                    state_d    = S_LO;
                    nib_data_d = byte_q[3:0];
                    nib_rs_d   = brs_q;
                end
            end
            S_LO: begin
                if (bus.i_nib_ready) state_d = S_LO_WAIT;
            end
            S_LO_WAIT: begin
                if (bus.i_nib_ready) begin
                    state_d = S_IDLE;
                    if (!init_done_q) begin
                        if (ibyte_q == 2'd3) begin
                            init_done_d = 1'b1;
                        end else begin
                            state_d    = S_HI;
                            ibyte_d    = ibyte_q + 2'd1;
                            byte_d     = next_init_byte;
                            brs_d      = 1'b0;
                            nib_data_d = next_init_byte[7:4];
                            nib_rs_d   = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_PWR_WAIT;
            step_q      <= '0;
            ibyte_q     <= '0;
            byte_q      <= '0;
            brs_q       <= 1'b0;
            nib_data_q  <= '0;
            nib_rs_q    <= 1'b0;
            init_done_q <= 1'b0;
            gap_run_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            ibyte_q     <= ibyte_d;
            byte_q      <= byte_d;
            brs_q       <= brs_d;
            nib_data_q  <= nib_data_d;
            nib_rs_q    <= nib_rs_d;
            init_done_q <= init_done_d;
            gap_run_q   <= gap_run_d;
        end
    end

    assign bus.o_nib_valid  = nib_valid;
    assign bus.o_nib_data   = nib_data_q;
    assign bus.o_nib_rs     = nib_rs_q;
    assign bus.o_byte_ready = (state_q == S_IDLE);
    assign bus.o_init_done  = init_done_q;

endmodule
